// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters for the IF stage.
// Combinational next-PC prediction; training from EX/MEM resolution; debug statistics.
//
// state   | meaning
// S_CLEAR | walking the table, invalidating one entry per cycle
// S_RUN   | predicting and training
module branch_target_predictor #(
    parameter int         XLEN     = 32,
    parameter int         DEPTH    = 16,
    parameter logic [1:0] CNT_INIT = 2'b01,
    parameter int         STAT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_lookup_valid,
    input  logic [XLEN-1:0]   i_lookup_pc,
    output logic              o_pred_hit,
    output logic              o_pred_taken,
    output logic [XLEN-1:0]   o_pred_target,
    input  logic              i_upd_valid,
    input  logic [XLEN-1:0]   i_upd_pc,
    input  logic              i_upd_taken,
    input  logic [XLEN-1:0]   i_upd_target,
    input  logic              i_upd_is_jump,
    input  logic              i_upd_mispredict,
    output logic              o_busy,
    output logic [STAT_W-1:0] o_stat_lookups,
    output logic [STAT_W-1:0] o_stat_mispred
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = XLEN - 2 - IDX_W;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_clr_idx;

    logic               r_valid  [DEPTH];
    logic [TAG_W-1:0]   r_tag    [DEPTH];
    logic [XLEN-1:0]    r_target [DEPTH];
    logic               r_jump   [DEPTH];
    logic [1:0]         r_cnt    [DEPTH];

    logic [STAT_W-1:0]  r_stat_lookups;
    logic [STAT_W-1:0]  r_stat_mispred;

    logic               w_run;
    logic               w_clr_last;
    logic [IDX_W-1:0]   w_lk_idx;
    logic [TAG_W-1:0]   w_lk_tag;
    logic               w_lk_hit;
    logic [IDX_W-1:0]   w_up_idx;
    logic [TAG_W-1:0]   w_up_tag;
    logic               w_up_hit;
    logic [1:0]         w_cnt_nxt;
    logic               w_unused;

    // Byte-offset bits never participate in index or tag.
    assign w_unused   = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};

    assign w_run      = (r_state == S_RUN);
    assign w_clr_last = (r_clr_idx == IDX_W'(DEPTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: if (w_clr_last) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_CLEAR) r_clr_idx <= r_clr_idx + IDX_W'(1);
        end
    end

    assign w_lk_idx = i_lookup_pc[IDX_W+1:2];
    assign w_lk_tag = i_lookup_pc[XLEN-1:IDX_W+2];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

    assign o_busy        = ~w_run;
    assign o_pred_hit    = w_run && w_lk_hit;
    assign o_pred_taken  = o_pred_hit && (r_jump[w_lk_idx] || r_cnt[w_lk_idx][1]);
    assign o_pred_target = o_pred_taken ? r_target[w_lk_idx] : i_lookup_pc + XLEN'(4);

    assign w_up_idx = i_upd_pc[IDX_W+1:2];
    assign w_up_tag = i_upd_pc[XLEN-1:IDX_W+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    // Counter value written on a training hit; jumps pin it to strongly taken.
    always_comb begin
        w_cnt_nxt = r_cnt[w_up_idx];
        if (i_upd_is_jump) begin
            w_cnt_nxt = 2'b11;
        end else if (i_upd_taken) begin
            if (r_cnt[w_up_idx] != 2'b11) w_cnt_nxt = r_cnt[w_up_idx] + 2'b01;
        end else begin
            if (r_cnt[w_up_idx] != 2'b00) w_cnt_nxt = r_cnt[w_up_idx] - 2'b01;
        end
    end

    // Table storage has no reset; the clear walk is what invalidates it.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (r_state == S_CLEAR) begin
                r_valid[r_clr_idx] <= 1'b0;
                r_cnt[r_clr_idx]   <= CNT_INIT;
            end else if (i_upd_valid) begin
                if (w_up_hit) begin
                    r_cnt[w_up_idx]  <= w_cnt_nxt;
                    r_jump[w_up_idx] <= i_upd_is_jump;
                    if (i_upd_taken) r_target[w_up_idx] <= i_upd_target;
                end else if (i_upd_taken) begin
                    r_valid[w_up_idx]  <= 1'b1;
                    r_tag[w_up_idx]    <= w_up_tag;
                    r_target[w_up_idx] <= i_upd_target;
                    r_jump[w_up_idx]   <= i_upd_is_jump;
                    r_cnt[w_up_idx]    <= i_upd_is_jump ? 2'b11 : 2'b10;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stat_lookups <= '0;
            r_stat_mispred <= '0;
        end else if (w_run) begin
            if (i_lookup_valid && (r_stat_lookups != '1))
                r_stat_lookups <= r_stat_lookups + STAT_W'(1);
            if (i_upd_valid && i_upd_mispredict && (r_stat_mispred != '1))
                r_stat_mispred <= r_stat_mispred + STAT_W'(1);
        end
    end

    assign o_stat_lookups = r_stat_lookups;
    assign o_stat_mispred = r_stat_mispred;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a table model.
module tb_branch_target_predictor;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int IDX_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid, upd_taken, upd_is_jump, upd_mispredict;
    logic [31:0] upd_pc, upd_target;
    logic        busy;
    logic [15:0] stat_lookups, stat_mispred;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    branch_target_predictor #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_INIT(2'b01), .STAT_W(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_lookup_valid(lookup_valid), .i_lookup_pc(lookup_pc),
        .o_pred_hit(pred_hit), .o_pred_taken(pred_taken), .o_pred_target(pred_target),
        .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_taken(upd_taken),
        .i_upd_target(upd_target), .i_upd_is_jump(upd_is_jump),
        .i_upd_mispredict(upd_mispredict),
        .o_busy(busy), .o_stat_lookups(stat_lookups), .o_stat_mispred(stat_mispred)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: per-entry table, cycles of clear walk remaining, plain-integer stats.
    bit          m_valid [DEPTH];
    int unsigned m_tag   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    bit          m_jump  [DEPTH];
    int          m_cnt   [DEPTH];
    int          m_clear_left = 0;
    int          m_lk = 0;
    int          m_mp = 0;
    bit          m_started = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return int'(pc >> (IDX_W + 2));
    endfunction

    // Inputs change 1 time unit after posedge, so the values seen at negedge
    // are exactly those the next posedge samples: compare first, then step.
    always @(negedge clk) begin
        int i;
        bit e_hit, e_taken;
        logic [31:0] e_tgt;
        if (m_started) begin
            e_hit = 0; e_taken = 0; e_tgt = lookup_pc + 32'd4;
            if (m_clear_left == 0) begin
                i = idx_of(lookup_pc);
                e_hit = m_valid[i] && (m_tag[i] == tag_of(lookup_pc));
                e_taken = e_hit && (m_jump[i] || m_cnt[i] >= 2);
                if (e_taken) e_tgt = m_tgt[i];
            end
            chk("busy", {31'd0, busy}, {31'd0, m_clear_left > 0});
            chk("pred_hit", {31'd0, pred_hit}, {31'd0, e_hit});
            chk("pred_taken", {31'd0, pred_taken}, {31'd0, e_taken});
            chk("pred_target", pred_target, e_tgt);
            chk("stat_lookups", {16'd0, stat_lookups}, 32'(m_lk));
            chk("stat_mispred", {16'd0, stat_mispred}, 32'(m_mp));
        end
        if (rst) begin
            m_started = 1;
            m_clear_left = DEPTH;
            m_lk = 0;
            m_mp = 0;
        end else if (m_clear_left > 0) begin
            i = DEPTH - m_clear_left;
            m_valid[i] = 0;
            m_cnt[i] = 1;
            m_clear_left--;
        end else if (m_started) begin
            if (lookup_valid && m_lk < 65535) m_lk++;
            if (upd_valid && upd_mispredict && m_mp < 65535) m_mp++;
            if (upd_valid) begin
                i = idx_of(upd_pc);
                if (m_valid[i] && m_tag[i] == tag_of(upd_pc)) begin
                    if (upd_taken) m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
                    else           m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
                    if (upd_is_jump) m_cnt[i] = 3;
                    if (upd_taken) m_tgt[i] = upd_target;
                    m_jump[i] = upd_is_jump;
                end else if (upd_taken) begin
                    m_valid[i] = 1;
                    m_tag[i]   = tag_of(upd_pc);
                    m_tgt[i]   = upd_target;
                    m_jump[i]  = upd_is_jump;
                    m_cnt[i]   = upd_is_jump ? 3 : 2;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic jp);
        upd_pc = pc; upd_taken = tk; upd_target = tg; upd_is_jump = jp;
        upd_mispredict = 1'b1; upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0; upd_mispredict = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        lookup_pc = pc;
        #1;
    endtask

    task automatic count_busy(input string nm);
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk(nm, 32'(n), 32'd16);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        pc = 32'($urandom_range(0, 63)) << 2;
        if ($urandom_range(0, 7) == 0) pc = pc | 32'hFFFFFF00;
        return pc | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        rst = 1'b1; lookup_valid = 1'b0; lookup_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_is_jump = 1'b0; upd_mispredict = 1'b0;

        // Reset and clear walk length
        tick();
        rst = 1'b0;
        look(32'h40);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_hit", {31'd0, pred_hit}, 32'd0);
        chk("rst_target", pred_target, 32'h44);
        chk("rst_stats", {stat_lookups, stat_mispred}, 32'd0);
        count_busy("clear_cycles");

        // Allocation and counter training
        lookup_valid = 1'b1;
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        look(32'h40);
        chk("alloc_hit", {31'd0, pred_hit}, 32'd1);
        chk("alloc_taken", {31'd0, pred_taken}, 32'd1);
        chk("alloc_target", pred_target, 32'h100);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        look(32'h40);
        chk("nt1_taken", {31'd0, pred_taken}, 32'd0);
        chk("nt1_target", pred_target, 32'h44);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        look(32'h40);
        chk("nt2_hit", {31'd0, pred_hit}, 32'd1);
        chk("nt2_taken", {31'd0, pred_taken}, 32'd0);
        for (int k = 0; k < 4; k++) upd(32'h40, 1'b1, 32'h200, 1'b0);
        look(32'h40);
        chk("sat_target", pred_target, 32'h200);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        look(32'h40);
        chk("sat_dec1_taken", {31'd0, pred_taken}, 32'd1);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        look(32'h40);
        chk("sat_dec2_taken", {31'd0, pred_taken}, 32'd0);

        // Aliasing replacement and jump behaviour
        upd(32'h80, 1'b1, 32'h300, 1'b0);
        look(32'h40);
        chk("alias_old_hit", {31'd0, pred_hit}, 32'd0);
        chk("alias_old_target", pred_target, 32'h44);
        look(32'h80);
        chk("alias_new_target", pred_target, 32'h300);
        upd(32'h48, 1'b1, 32'h500, 1'b1);
        upd(32'h48, 1'b0, 32'h0, 1'b0);
        look(32'h48);
        chk("jal_taken", {31'd0, pred_taken}, 32'd1);
        chk("jal_target", pred_target, 32'h500);

        // Same-cycle lookup and update, then address wrap
        lookup_pc = 32'h40;
        upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h600; upd_is_jump = 1'b0;
        upd_valid = 1'b1;
        #1;
        chk("same_cycle_hit", {31'd0, pred_hit}, 32'd0);
        chk("same_cycle_target", pred_target, 32'h44);
        tick();
        upd_valid = 1'b0;
        #1;
        chk("next_cycle_hit", {31'd0, pred_hit}, 32'd1);
        chk("next_cycle_target", pred_target, 32'h600);
        look(32'hFFFFFFFC);
        chk("wrap_target", pred_target, 32'h0);

        // Reset mid-walk restarts the full walk
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        chk("midwalk_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        count_busy("restart_cycles");
        look(32'h40);
        chk("restart_cleared_hit", {31'd0, pred_hit}, 32'd0);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            lookup_valid = $urandom_range(0, 1);
            lookup_pc = rand_pc();
            upd_valid = $urandom_range(0, 1);
            upd_pc = rand_pc();
            upd_taken = $urandom_range(0, 1);
            upd_target = $urandom;
            upd_is_jump = ($urandom_range(0, 3) == 0);
            upd_mispredict = $urandom_range(0, 1);
            tick();
        end
        rst = 1'b0;
        upd_valid = 1'b0;
        for (int k = 0; k < 20; k++) tick();

        // Drive both statistics into saturation
        lookup_valid = 1'b1;
        upd_valid = 1'b1;
        upd_mispredict = 1'b1;
        for (int k = 0; k < 65545; k++) begin
            lookup_pc = rand_pc();
            upd_pc = rand_pc();
            upd_taken = $urandom_range(0, 1);
            upd_target = $urandom;
            upd_is_jump = ($urandom_range(0, 3) == 0);
            tick();
        end
        chk("lookups_saturated", {16'd0, stat_lookups}, 32'hFFFF);
        chk("mispred_saturated", {16'd0, stat_mispred}, 32'hFFFF);
        tick();
        chk("mispred_held", {16'd0, stat_mispred}, 32'hFFFF);
        upd_valid = 1'b0;
        lookup_valid = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
